// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and helpers for the servo PWM array.
//   Timing defaults assume a 50 MHz clock: 20 ms frame, 1.0/1.5/2.0 ms pulses.
//   clamp() limits a signed integer to an inclusive range.
package servo_pkg;

    localparam int unsigned PERIOD_CYC_DEF = 1_000_000;
    localparam int unsigned MIN_CYC_DEF    = 50_000;
    localparam int unsigned MID_CYC_DEF    = 75_000;
    localparam int unsigned MAX_CYC_DEF    = 100_000;
    localparam int unsigned IN_LIM_DEF     = 256;
    localparam int unsigned GAIN_DEF       = 97;
    localparam int unsigned SLEW_STEP_DEF  = 500;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo output.
//   Saturates and scales the signed input word into a target pulse width, slews the
//   current width toward the target once per frame, and drives the pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   data_valid   capture strobe for data
//   data         signed input word for this channel
//   cnt_next     frame counter value for the next cycle
//   wrap         high in the last cycle of a frame (next edge starts a new frame)
//   armed_next   armed flag value for the next cycle
//   pwm_out      registered servo pulse
//   settled      registered (cur == tgt)
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned MIN_CYC   = MIN_CYC_DEF,
    parameter int unsigned MID_CYC   = MID_CYC_DEF,
    parameter int unsigned MAX_CYC   = MAX_CYC_DEF,
    parameter int unsigned IN_LIM    = IN_LIM_DEF,
    parameter int unsigned GAIN      = GAIN_DEF,
    parameter int unsigned SLEW_STEP = SLEW_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  cnt_next,
    input  logic              wrap,
    input  logic              armed_next,
    output logic              pwm_out,
    output logic              settled
);

    // Product width holds +/-(IN_LIM*GAIN) plus sign.
    localparam int unsigned PROD_W = $clog2(IN_LIM * GAIN + 1) + 1;
    localparam logic signed [PROD_W-1:0] GAIN_S = PROD_W'(GAIN);
    // A step larger than the full width range behaves like an immediate jump anyway.
    localparam int unsigned SLEW_EFF = (SLEW_STEP > MAX_CYC) ? MAX_CYC : SLEW_STEP;
    localparam logic [CNT_W-1:0] SLEW_W = CNT_W'(SLEW_EFF);
    localparam logic [CNT_W-1:0] MID_W  = CNT_W'(MID_CYC);

    logic signed [DATA_W-1:0] data_s;
    logic signed [PROD_W-1:0] sat_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [CNT_W-1:0]         tgt_calc;
    logic [CNT_W-1:0]         tgt_q, tgt_d;
    logic [CNT_W-1:0]         cur_q, cur_d;
    logic [CNT_W-1:0]         diff_abs;
    logic                     pwm_q, settled_q;
    int                       data_int, sat_int, tgt_int;

    assign data_s = data;

    always_comb begin
        data_int = int'(data_s);
        sat_int  = clamp(data_int, -int'(IN_LIM), int'(IN_LIM));
        sat_s    = PROD_W'(sat_int);
        prod_s   = sat_s * GAIN_S;
        tgt_int  = clamp(int'(MID_CYC) + int'(prod_s), int'(MIN_CYC), int'(MAX_CYC));
        tgt_calc = CNT_W'(tgt_int);
    end

    // A strobe coinciding with wrap only updates tgt; the slew below still sees tgt_q.
    assign tgt_d = data_valid ? tgt_calc : tgt_q;

    always_comb begin
        cur_d    = cur_q;
        diff_abs = (tgt_q >= cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
        if (wrap) begin
            if ((SLEW_STEP == 0) || (diff_abs <= SLEW_W)) begin
                cur_d = tgt_q;
            end else if (tgt_q > cur_q) begin
                cur_d = cur_q + SLEW_W;
            end else begin
                cur_d = cur_q - SLEW_W;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q     <= MID_W;
            cur_q     <= MID_W;
            pwm_q     <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            // Computed from next-cycle values so the registered pulse lines up with the counter.
            pwm_q     <= armed_next && (cnt_next < cur_d);
            settled_q <= (cur_d == tgt_d);
        end
    end

    assign pwm_out = pwm_q;
    assign settled = settled_q;

endmodule

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: N-channel hobby-servo PWM generator.
//   Free-running frame counter with a one-cycle frame_tick, an enable that only arms at frame
//   boundaries, and one servo_channel per axis.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           output enable (level)
//   data_valid   one-cycle strobe, data holds a new sample for all channels
//   data         channel i = data[i*DATA_W +: DATA_W], two's complement
//   pwm_out      servo pulse per channel
//   frame_tick   high for one cycle at the start of each frame
//   settled      per channel, current width equals target
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int unsigned MIN_CYC    = MIN_CYC_DEF,
    parameter int unsigned MAX_CYC    = MAX_CYC_DEF,
    parameter int unsigned MID_CYC    = MID_CYC_DEF,
    parameter int unsigned IN_LIM     = IN_LIM_DEF,
    parameter int unsigned GAIN       = GAIN_DEF,
    parameter int unsigned SLEW_STEP  = SLEW_STEP_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     data_valid,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic [N_CH-1:0]          pwm_out,
    output logic                     frame_tick,
    output logic [N_CH-1:0]          settled
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             armed_q, armed_d;
    logic             frame_tick_q;

    assign wrap  = (cnt_q == CNT_LAST);
    assign cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
    // Arm only across a frame boundary; dropping en disarms at any edge.
    assign armed_d = wrap ? en : (armed_q & en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            frame_tick_q <= wrap;
        end
    end

    assign frame_tick = frame_tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_channel #(
            .DATA_W    (DATA_W),
            .CNT_W     (CNT_W),
            .MIN_CYC   (MIN_CYC),
            .MID_CYC   (MID_CYC),
            .MAX_CYC   (MAX_CYC),
            .IN_LIM    (IN_LIM),
            .GAIN      (GAIN),
            .SLEW_STEP (SLEW_STEP)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .data_valid (data_valid),
            .data       (data[i*DATA_W +: DATA_W]),
            .cnt_next   (cnt_d),
            .wrap       (wrap),
            .armed_next (armed_d),
            .pwm_out    (pwm_out[i]),
            .settled    (settled[i])
        );
    end

`ifndef SYNTHESIS
    param_legal: assert property (@(posedge clk)
        (MIN_CYC <= MID_CYC) && (MID_CYC <= MAX_CYC) && (MAX_CYC < PERIOD_CYC));
`endif

endmodule

// File: tb/tb_servo_pwm_array.sv
// Testbench for servo_pwm_array with small frame parameters.
module tb_servo_pwm_array;

    localparam int N_CH   = 3;
    localparam int DATA_W = 16;
    localparam int PERIOD = 100;
    localparam int MINW   = 10;
    localparam int MIDW   = 15;
    localparam int MAXW   = 20;
    localparam int LIM    = 5;
    localparam int GAIN   = 1;
    localparam int SLEW   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   en = 1'b0;
    logic                   data_valid = 1'b0;
    logic [N_CH*DATA_W-1:0] data = '0;
    logic [N_CH-1:0]        pwm_out;
    logic                   frame_tick;
    logic [N_CH-1:0]        settled;

    always #5 clk = ~clk;

    servo_pwm_array #(
        .N_CH       (N_CH),
        .DATA_W     (DATA_W),
        .PERIOD_CYC (PERIOD),
        .MIN_CYC    (MINW),
        .MAX_CYC    (MAXW),
        .MID_CYC    (MIDW),
        .IN_LIM     (LIM),
        .GAIN       (GAIN),
        .SLEW_STEP  (SLEW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_valid (data_valid),
        .data       (data),
        .pwm_out    (pwm_out),
        .frame_tick (frame_tick),
        .settled    (settled)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position in frame, per-channel widths, arming.
    int    m_pos;
    int    m_cur[N_CH];
    int    m_tgt[N_CH];
    bit    m_armed;
    bit    m_tick;
    int    wid[N_CH];
    int    bad_cnt;
    string bad_msg;

    function automatic int target_of(input logic [DATA_W-1:0] w);
        int v;
        int t;
        v = int'($signed(w));
        if (v > LIM) v = LIM;
        if (v < -LIM) v = -LIM;
        t = MIDW + v * GAIN;
        if (t < MINW) t = MINW;
        if (t > MAXW) t = MAXW;
        return t;
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_armed = 1'b0;
        m_tick = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_cur[c] = MIDW;
            m_tgt[c] = MIDW;
        end
    endtask

    task automatic model_edge();
        bit wrap;
        int d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wrap = (m_pos == PERIOD - 1);
        if (wrap) begin
            for (int c = 0; c < N_CH; c++) begin
                d = m_tgt[c] - m_cur[c];
                if (d > SLEW) m_cur[c] = m_cur[c] + SLEW;
                else if (d < -SLEW) m_cur[c] = m_cur[c] - SLEW;
                else m_cur[c] = m_tgt[c];
            end
        end
        if (data_valid) begin
            for (int c = 0; c < N_CH; c++) m_tgt[c] = target_of(data[c*DATA_W +: DATA_W]);
        end
        m_armed = wrap ? en : (m_armed && en);
        m_tick  = wrap;
        m_pos   = wrap ? 0 : m_pos + 1;
    endtask

    function automatic logic [2*N_CH:0] exp_out();
        logic [N_CH-1:0] p;
        logic [N_CH-1:0] s;
        for (int c = 0; c < N_CH; c++) begin
            p[c] = m_armed && (m_pos < m_cur[c]);
            s[c] = (m_cur[c] == m_tgt[c]);
        end
        return {p, m_tick, s};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Steps n cycles, recording per-channel high counts and cycles that disagree with the model.
    task automatic run_cycles(input int n);
        logic [2*N_CH:0] act;
        logic [2*N_CH:0] exp;
        for (int c = 0; c < N_CH; c++) wid[c] = 0;
        bad_cnt = 0;
        bad_msg = "";
        for (int k = 0; k < n; k++) begin
            act = {pwm_out, frame_tick, settled};
            exp = exp_out();
            for (int c = 0; c < N_CH; c++) if (pwm_out[c] === 1'b1) wid[c]++;
            if (act !== exp) begin
                if (bad_cnt == 0) bad_msg = $sformatf("pos %0d got %b want %b", m_pos, act, exp);
                bad_cnt++;
            end
            step();
        end
    endtask

    task automatic goto_pos(input int p);
        for (int k = 0; k < PERIOD && m_pos != p; k++) step();
    endtask

    task automatic test_reset();
        en = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pwm_out, frame_tick, settled} !== 7'b000_0_111) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000111", {pwm_out, frame_tick, settled});
        end
        step();
        step();
        rst_n = 1'b1;
        run_cycles(PERIOD);
        checks++;
        if (bad_cnt !== 0) begin errors++; $display("FAIL reset_frame0 model: %s", bad_msg); end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (wid[c] !== 0) begin
                errors++;
                $display("FAIL reset_frame0_width ch%0d: got %0d want 0", c, wid[c]);
            end
        end
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b want 1", frame_tick); end
        run_cycles(PERIOD);
        checks++;
        if (bad_cnt !== 0) begin errors++; $display("FAIL reset_frame1 model: %s", bad_msg); end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (wid[c] !== MIDW) begin
                errors++;
                $display("FAIL mid_width ch%0d: got %0d want %0d", c, wid[c], MIDW);
            end
        end
        checks++;
        if (settled !== 3'b111) begin errors++; $display("FAIL settled_mid: got %b want 111", settled); end
    endtask

    task automatic test_slew_up();
        int exp_w0[4] = '{17, 19, 20, 20};
        bit exp_s0[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        goto_pos(50);
        data = {16'd0, 16'd0, 16'd5};
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        goto_pos(0);
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (settled[0] !== exp_s0[f]) begin
                errors++;
                $display("FAIL slew_up_settled frame %0d: got %b want %b", f, settled[0], exp_s0[f]);
            end
            run_cycles(PERIOD);
            checks++;
            if ({wid[0], wid[1], wid[2], bad_cnt} !== {exp_w0[f], MIDW, MIDW, 0}) begin
                errors++;
                $display("FAIL slew_up frame %0d: got %0d,%0d,%0d (%0d bad) want %0d,15,15 %s",
                         f, wid[0], wid[1], wid[2], bad_cnt, exp_w0[f], bad_msg);
            end
        end
    endtask

    task automatic test_slew_extremes();
        int exp_w1[4] = '{13, 11, 10, 10};
        int exp_w2[4] = '{17, 19, 20, 20};
        goto_pos(50);
        data = {16'd1000, 16'h8000, 16'd5};
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        goto_pos(0);
        for (int f = 0; f < 4; f++) begin
            run_cycles(PERIOD);
            checks++;
            if ({wid[0], wid[1], wid[2], bad_cnt} !== {MAXW, exp_w1[f], exp_w2[f], 0}) begin
                errors++;
                $display("FAIL slew_ext frame %0d: got %0d,%0d,%0d (%0d bad) want 20,%0d,%0d %s",
                         f, wid[0], wid[1], wid[2], bad_cnt, exp_w1[f], exp_w2[f], bad_msg);
            end
            for (int c = 0; c < N_CH; c++) begin
                checks++;
                if (wid[c] < MINW || wid[c] > MAXW) begin
                    errors++;
                    $display("FAIL width_range ch%0d: got %0d want 10..20", c, wid[c]);
                end
            end
        end
    endtask

    task automatic test_enable();
        en = 1'b1;
        repeat (4) step();
        checks++;
        if (pwm_out !== 3'b111) begin errors++; $display("FAIL en_pulse_on: got %b want 111", pwm_out); end
        en = 1'b0;
        step();
        checks++;
        if (pwm_out !== 3'b000) begin errors++; $display("FAIL en_cut: got %b want 000", pwm_out); end
        run_cycles(45);
        checks++;
        if ({wid[0], wid[1], wid[2], bad_cnt} !== {0, 0, 0, 0}) begin
            errors++;
            $display("FAIL en_off: got %0d,%0d,%0d (%0d bad) want 0,0,0 %s",
                     wid[0], wid[1], wid[2], bad_cnt, bad_msg);
        end
        en = 1'b1;
        run_cycles(50);
        checks++;
        if ({wid[0], wid[1], wid[2], bad_cnt} !== {0, 0, 0, 0}) begin
            errors++;
            $display("FAIL en_midframe: got %0d,%0d,%0d (%0d bad) want 0,0,0 %s",
                     wid[0], wid[1], wid[2], bad_cnt, bad_msg);
        end
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL en_tick: got %b want 1", frame_tick); end
        run_cycles(PERIOD);
        checks++;
        if ({wid[0], wid[1], wid[2], bad_cnt} !== {20, 10, 20, 0}) begin
            errors++;
            $display("FAIL en_rearm: got %0d,%0d,%0d (%0d bad) want 20,10,20 %s",
                     wid[0], wid[1], wid[2], bad_cnt, bad_msg);
        end
    endtask

    task automatic test_capture_at_wrap();
        goto_pos(50);
        data = '0;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        goto_pos(0);
        repeat (4) run_cycles(PERIOD);
        checks++;
        if (settled !== 3'b111) begin errors++; $display("FAIL recentre: got %b want 111", settled); end
        goto_pos(PERIOD - 1);
        data = {16'd0, 16'd0, 16'hFFFB};
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        checks++;
        if (settled !== 3'b110) begin errors++; $display("FAIL wrap_settled: got %b want 110", settled); end
        run_cycles(PERIOD);
        checks++;
        if ({wid[0], bad_cnt} !== {15, 0}) begin
            errors++;
            $display("FAIL wrap_old_tgt: got %0d (%0d bad) want 15 %s", wid[0], bad_cnt, bad_msg);
        end
        run_cycles(PERIOD);
        checks++;
        if ({wid[0], bad_cnt} !== {13, 0}) begin
            errors++;
            $display("FAIL wrap_new_tgt: got %0d (%0d bad) want 13 %s", wid[0], bad_cnt, bad_msg);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int bad_sum = 0;
        goto_pos(50);
        data = {16'd0, 16'd0, 16'd5};
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        goto_pos(0);
        repeat (5) begin
            run_cycles(PERIOD);
            bad_sum += bad_cnt;
        end
        checks++;
        if ({wid[0], bad_sum} !== {20, 0}) begin
            errors++;
            $display("FAIL rst_setup: got %0d (%0d bad) want 20 %s", wid[0], bad_sum, bad_msg);
        end
        repeat (10) step();
        checks++;
        if (pwm_out !== 3'b111) begin errors++; $display("FAIL rst_prepulse: got %b want 111", pwm_out); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pwm_out, frame_tick, settled} !== 7'b000_0_111) begin
            errors++;
            $display("FAIL rst_async: got %b want 0000111", {pwm_out, frame_tick, settled});
        end
        step();
        step();
        rst_n = 1'b1;
        run_cycles(PERIOD);
        checks++;
        if ({wid[0], wid[1], wid[2], bad_cnt} !== {0, 0, 0, 0}) begin
            errors++;
            $display("FAIL rst_frame0: got %0d,%0d,%0d (%0d bad) want 0,0,0 %s",
                     wid[0], wid[1], wid[2], bad_cnt, bad_msg);
        end
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL rst_tick: got %b want 1", frame_tick); end
        run_cycles(PERIOD);
        checks++;
        if ({wid[0], wid[1], wid[2], bad_cnt} !== {15, 15, 15, 0}) begin
            errors++;
            $display("FAIL rst_frame1: got %0d,%0d,%0d (%0d bad) want 15,15,15 %s",
                     wid[0], wid[1], wid[2], bad_cnt, bad_msg);
        end
    endtask

    task automatic test_random();
        logic [2*N_CH:0] act;
        logic [2*N_CH:0] exp;
        en = 1'b1;
        for (int k = 0; k < 25 * PERIOD; k++) begin
            if ($urandom_range(0, 149) == 0) en = !en;
            data_valid = ($urandom_range(0, 39) == 0) ||
                         ((m_pos == PERIOD - 1) && ($urandom_range(0, 3) == 0));
            if (data_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    if ($urandom_range(0, 1) == 1) data[c*DATA_W +: DATA_W] = 16'($urandom);
                    else data[c*DATA_W +: DATA_W] = 16'($urandom_range(0, 14)) - 16'd7;
                end
            end
            step();
            act = {pwm_out, frame_tick, settled};
            exp = exp_out();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random cycle %0d pos %0d: got %b want %b", k, m_pos, act, exp);
            end
        end
        data_valid = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_slew_up();
        test_slew_extremes();
        test_enable();
        test_capture_at_wrap();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
